// File: rtl/data_sync.sv
// data_sync: moves a source-domain bus into the clk domain.
// Only the bus_enable qualifier is synchronized. The bus itself is sampled
// once, on the first clk cycle after the synchronized enable rises.
module data_sync #(
   parameter int unsigned BUS_WIDTH  = 8,
   parameter int unsigned NUM_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [BUS_WIDTH-1:0] unsync_bus,
   input  logic                 bus_enable,
   output logic [BUS_WIDTH-1:0] sync_bus,
   output logic                 enable_pulse
);

   localparam int unsigned LAST = NUM_STAGES - 1;

   logic [NUM_STAGES-1:0] sync;
   logic                  q;
   logic                  sel;

   // Enable synchronizer chain; sync[0] is the only flop that sees bus_enable
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync <= '0;
      end else begin
         sync <= {sync[NUM_STAGES-2:0], bus_enable};
      end
   end

   // Previous value of the synchronized enable, for edge detection
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= 1'b0;
      end else begin
         q <= sync[LAST];
      end
   end

   // Rising edge of the synchronized enable selects the capture cycle
   always_comb begin
      sel = sync[LAST] & ~q;
   end

   // Capture the (stable) source bus and raise the one-cycle strobe
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_bus     <= '0;
         enable_pulse <= 1'b0;
      end else begin
         enable_pulse <= sel;
         if (sel) begin
            sync_bus <= unsync_bus;
         end
      end
   end

endmodule

// File: tb/tb_data_sync.sv
// Scoreboard bench for data_sync: each driven transfer pushes the expected
// data and the expected pulse cycle; monitors pop on every enable_pulse.
module tb_data_sync;

   typedef struct {
      logic [7:0] data;
      int         cyc;
   } exp_t;

   logic       clk;
   logic       rst;
   logic [7:0] unsync_bus;
   logic       bus_enable;
   logic [7:0] sync_bus;
   logic       enable_pulse;

   logic       rst3;
   logic [7:0] unsync_bus3;
   logic       bus_enable3;
   logic [7:0] sync_bus3;
   logic       enable_pulse3;

   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   exp_t sb2[$];
   exp_t sb3[$];

   data_sync #(.BUS_WIDTH(8), .NUM_STAGES(2)) dut2 (
      .clk          (clk),
      .rst          (rst),
      .unsync_bus   (unsync_bus),
      .bus_enable   (bus_enable),
      .sync_bus     (sync_bus),
      .enable_pulse (enable_pulse)
   );

   data_sync #(.BUS_WIDTH(8), .NUM_STAGES(3)) dut3 (
      .clk          (clk),
      .rst          (rst3),
      .unsync_bus   (unsync_bus3),
      .bus_enable   (bus_enable3),
      .sync_bus     (sync_bus3),
      .enable_pulse (enable_pulse3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge counter: at a negedge, cyc is the number of rising edges so far
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Monitor for the 2-stage instance
   always @(negedge clk) begin
      if (sb2.size() > 0 && cyc > sb2[0].cyc) begin
         check("s2_missed_pulse", 32'(cyc), 32'(sb2[0].cyc));
         void'(sb2.pop_front());
      end
      if (enable_pulse) begin
         if (sb2.size() == 0) begin
            check("s2_spurious_pulse", 32'(1), 32'(0));
         end else begin
            exp_t e;
            e = sb2.pop_front();
            check("s2_pulse_cycle", 32'(cyc), 32'(e.cyc));
            check("s2_pulse_data", 32'(sync_bus), 32'(e.data));
         end
      end
   end

   // Monitor for the 3-stage instance
   always @(negedge clk) begin
      if (sb3.size() > 0 && cyc > sb3[0].cyc) begin
         check("s3_missed_pulse", 32'(cyc), 32'(sb3[0].cyc));
         void'(sb3.pop_front());
      end
      if (enable_pulse3) begin
         if (sb3.size() == 0) begin
            check("s3_spurious_pulse", 32'(1), 32'(0));
         end else begin
            exp_t e;
            e = sb3.pop_front();
            check("s3_pulse_cycle", 32'(cyc), 32'(e.cyc));
            check("s3_pulse_data", 32'(sync_bus3), 32'(e.data));
         end
      end
   end

   // Raise enable on a negedge with data, expecting a pulse NUM_STAGES+1 edges on
   task automatic start2(input logic [7:0] d);
      exp_t e;
      @(negedge clk);
      unsync_bus = d;
      bus_enable = 1'b1;
      e.data = d;
      e.cyc  = cyc + 3;
      sb2.push_back(e);
   endtask

   // Half-period enable at phase p ns after a rising edge
   task automatic glitch(input int p, input logic [7:0] d);
      exp_t e;
      int   c;
      @(posedge clk);
      #1;
      c = cyc;
      unsync_bus = d;
      #(p - 1);
      bus_enable = 1'b1;
      #5;
      bus_enable = 1'b0;
      if (p > 5) begin
         e.data = d;
         e.cyc  = c + 3;
         sb2.push_back(e);
      end
      repeat (6) @(negedge clk);
   endtask

   initial begin
      exp_t e;
      rst         = 1'b0;
      unsync_bus  = 8'hA5;
      bus_enable  = 1'b1;
      rst3        = 1'b0;
      unsync_bus3 = 8'h00;
      bus_enable3 = 1'b0;

      // Reset holds outputs low despite an active enable
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("rst_sync_bus", 32'(sync_bus), 32'h00);
         check("rst_pulse", 32'(enable_pulse), 32'h0);
      end

      // Release with enable already high counts as a new rising edge
      @(negedge clk);
      rst = 1'b1;
      e.data = 8'hA5;
      e.cyc  = cyc + 3;
      sb2.push_back(e);
      repeat (6) @(negedge clk);
      bus_enable = 1'b0;
      repeat (4) @(negedge clk);
      check("post_rst_hold", 32'(sync_bus), 32'hA5);

      // Single transfer
      start2(8'h3C);
      repeat (3) @(negedge clk);
      bus_enable = 1'b0;
      repeat (4) @(negedge clk);
      check("single_hold", 32'(sync_bus), 32'h3C);

      // Long enable: data changes after capture, only one pulse
      start2(8'h3C);
      repeat (3) @(negedge clk);
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         unsync_bus = 8'(i * 7 + 1);
      end
      check("long_hold_high", 32'(sync_bus), 32'h3C);
      bus_enable = 1'b0;
      repeat (5) @(negedge clk);
      check("long_hold_low", 32'(sync_bus), 32'h3C);

      // Back-to-back: high 3 cycles, low 2 cycles
      start2(8'h11);
      repeat (3) @(negedge clk);
      bus_enable = 1'b0;
      repeat (1) @(negedge clk);
      start2(8'h22);
      repeat (3) @(negedge clk);
      bus_enable = 1'b0;
      repeat (5) @(negedge clk);
      check("b2b_final", 32'(sync_bus), 32'h22);

      // Glitch sweep across phases (edge-aligned phases skipped)
      for (int p = 1; p < 10; p++) begin
         if (p != 5) glitch(p, 8'(8'h40 + p));
      end
      check("glitch_final", 32'(sync_bus), 32'h49);

      // Asynchronous reset clears outputs without a clock edge
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_bus", 32'(sync_bus), 32'h00);
      check("async_rst_pulse", 32'(enable_pulse), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      check("async_rst_after", 32'(sync_bus), 32'h00);

      // Three-stage instance: latency is one edge longer
      @(negedge clk);
      rst3 = 1'b1;
      repeat (3) @(negedge clk);
      unsync_bus3 = 8'h5A;
      bus_enable3 = 1'b1;
      e.data = 8'h5A;
      e.cyc  = cyc + 4;
      sb3.push_back(e);
      repeat (6) @(negedge clk);
      bus_enable3 = 1'b0;
      repeat (5) @(negedge clk);
      check("s3_hold", 32'(sync_bus3), 32'h5A);

      // Mid-transfer reset aborts the transfer
      unsync_bus3 = 8'h77;
      bus_enable3 = 1'b1;
      @(negedge clk);
      rst3 = 1'b0;
      bus_enable3 = 1'b0;
      @(negedge clk);
      check("s3_abort_bus", 32'(sync_bus3), 32'h00);
      rst3 = 1'b1;
      repeat (8) @(negedge clk);
      check("s3_abort_after", 32'(sync_bus3), 32'h00);

      check("sb2_drained", 32'(sb2.size()), 32'h0);
      check("sb3_drained", 32'(sb3.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/data_sync.md
DATA_SYNC -- requirements
Module: data_sync

Interface
REQ-001 The block SHALL have parameter BUS_WIDTH, default 8: width of the data bus crossing into the clk domain.
REQ-002 The block SHALL have parameter NUM_STAGES, default 2: depth of the enable synchronizer chain; legal values are 2 to 4.
REQ-003 The block SHALL have port clk, input, 1 bit: destination-domain clock; all flops are clocked on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous assert and active-low; all flops clear while rst=0.
REQ-005 The block SHALL have port unsync_bus, input, BUS_WIDTH bits: source-domain data, held stable by the source while bus_enable is high.
REQ-006 The block SHALL have port bus_enable, input, 1 bit: source-domain level qualifier for unsync_bus; it is asynchronous to clk.
REQ-007 The block SHALL have port sync_bus, output, BUS_WIDTH bits: registered copy of unsync_bus in the clk domain.
REQ-008 The block SHALL have port enable_pulse, output, 1 bit: registered one-cycle strobe, high in the cycle that sync_bus takes a new value.

Function
REQ-009 The block SHALL pass bus_enable through a chain of NUM_STAGES flops (sync[0] to sync[N-1]); only sync[N-1] is used downstream.
REQ-010 The block SHALL hold a previous-value flop q, loaded with sync[N-1] every cycle.
REQ-011 The block SHALL form the rising-edge term sel = sync[N-1] AND NOT q (combinational, internal only).
REQ-012 On a clk edge with sel=1, the block SHALL load unsync_bus into sync_bus and set enable_pulse=1 on that same edge.
REQ-013 On a clk edge with sel=0, the block SHALL hold sync_bus and set enable_pulse=0.
REQ-014 Latency: if bus_enable rises before edge k and meets setup, sync_bus and enable_pulse SHALL update at edge k+NUM_STAGES (edge k+2 at the default).
REQ-015 enable_pulse SHALL be exactly one cycle wide for each low-to-high transition of sync[N-1], however long bus_enable stays high.
REQ-016 No new pulse SHALL occur while bus_enable stays high; a new pulse requires bus_enable to be seen low for at least one cycle at sync[N-1].
REQ-017 If bus_enable is high for less than one clk period, the block SHALL give no pulse or exactly one pulse, never two.
REQ-018 The block SHALL NOT pass unsync_bus through any synchronizer flop; the bus is captured only in the sel cycle.
REQ-019 sync_bus SHALL keep its last captured value indefinitely, including after bus_enable falls.
REQ-020 The block SHALL contain no combinational path from any input to any output.

Reset
REQ-021 While rst=0, the block SHALL force sync[], q, sync_bus and enable_pulse to 0 immediately, without waiting for clk.
REQ-022 After rst deasserts with bus_enable already high, the block SHALL treat it as a new rising edge and pulse once, NUM_STAGES edges later.
REQ-023 Reset asserted mid-transfer SHALL abort the transfer: enable_pulse=0, sync_bus=0, and no delayed pulse after release unless REQ-022 applies.

Verification
REQ-024 Reset: rst=0 with unsync_bus=8'hA5 and bus_enable=1 -> sync_bus=8'h00 and enable_pulse=0 for the whole reset period.
REQ-025 Single transfer: unsync_bus=8'h3C, bus_enable rises before edge k -> enable_pulse=1 only at edge k+2, sync_bus=8'h3C from edge k+2.
REQ-026 Long enable: bus_enable held high 20 cycles with unsync_bus changing after edge k+2 -> exactly one pulse, sync_bus stays 8'h3C.
REQ-027 Back-to-back: 8'h11 then 8'h22, each with bus_enable high 3 cycles and low 2 cycles -> two pulses, sync_bus 8'h11 then 8'h22.
REQ-028 Glitch: bus_enable high for half a clk period, swept across phases -> 0 or 1 pulse, never 2.
REQ-029 NUM_STAGES=3, then mid-transfer reset: rise before edge k -> pulse at edge k+3; rst pulsed low at edge k+1 with bus_enable=0 at release -> no pulse.
